// File: rtl/main_fsm.sv
// Note detector: captures an FFT frame into a magnitude-squared RAM, finds the
// peak bin in 1..255, maps it to a note/octave and snaps it onto a scale mask.
module main_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        fft_done,
    input  logic        fft_read_valid,
    input  logic [8:0]  fft_address,
    input  logic [17:0] data_in_real,
    input  logic [17:0] data_in_imag,
    input  logic [11:0] scale,
    input  logic [8:0]  result_address,
    output logic [35:0] result_data,
    output logic [3:0]  note_name,
    output logic [2:0]  note_octave,
    output logic        note_done,
    output logic        done
);

    localparam int unsigned MAG_W  = 36;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CAPTURE = 3'd1;
    localparam logic [2:0] NORM    = 3'd2;
    localparam logic [2:0] SNAP    = 3'd3;
    localparam logic [2:0] OUT     = 3'd4;

    // Lower edges of notes 1..11 and of the next octave's note 0, mantissa 128..255
    localparam logic [95:0] BOUNDS = {8'd249, 8'd235, 8'd222, 8'd209, 8'd197, 8'd186,
                                      8'd176, 8'd166, 8'd157, 8'd148, 8'd140, 8'd132};

    logic [2:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [MAG_W-1:0]  s1_mag_q, s1_mag_d;
    logic [MAG_W-1:0]  max_q, max_d;
    logic [7:0]        peak_q, peak_d;
    logic [3:0]        norm_note_q, norm_note_d;
    logic [2:0]        norm_oct_q, norm_oct_d;
    logic              none_q, none_d;
    logic [3:0]        note_name_q, note_name_d;
    logic [2:0]        note_octave_q, note_octave_d;
    logic              note_done_q, note_done_d;
    logic              done_q, done_d;
    logic [MAG_W-1:0]  result_data_q;

    logic [MAG_W-1:0]  mem [DEPTH];

    logic signed [MAG_W-1:0] re_sx, im_sx;
    logic [MAG_W-1:0]  re_sq, im_sq, mag;
    logic              accept;
    logic [2:0]        msb;
    logic [7:0]        norm_m;
    logic [3:0]        cnt;
    logic [3:0]        snap_note;
    logic [2:0]        snap_oct;
    logic              found;
    logic [4:0]        dn_sum, up_sum;
    logic [3:0]        dn_cls, up_cls;

    // Magnitude squared; 36 bits is exact since the worst case is 2^35
    always_comb begin
        re_sx  = MAG_W'(signed'(data_in_real));
        im_sx  = MAG_W'(signed'(data_in_imag));
        re_sq  = re_sx * re_sx;
        im_sq  = im_sx * im_sx;
        mag    = re_sq + im_sq;
        accept = (state_q == CAPTURE) && !last_q && fft_read_valid;
    end

    // Peak bin to note: octave from the leading one, note from the mantissa
    always_comb begin
        msb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (peak_q[i]) msb = 3'(i);
        end
        norm_m = 8'(peak_q << (3'd7 - msb));
        cnt    = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (norm_m >= BOUNDS[i*8 +: 8]) cnt = cnt + 4'd1;
        end
    end

    // Nearest allowed note; the downward candidate is tried first so ties go lower
    always_comb begin
        snap_note = norm_note_q;
        snap_oct  = norm_oct_q;
        found     = 1'b0;
        dn_sum    = 5'd0;
        up_sum    = 5'd0;
        dn_cls    = 4'd0;
        up_cls    = 4'd0;
        if (scale != '0 && !scale[norm_note_q]) begin
            for (int d = 1; d <= 6; d++) begin
                dn_sum = {1'b0, norm_note_q} + 5'd12 - 5'(d);
                up_sum = {1'b0, norm_note_q} + 5'(d);
                dn_cls = (dn_sum >= 5'd12) ? 4'(dn_sum - 5'd12) : 4'(dn_sum);
                up_cls = (up_sum >= 5'd12) ? 4'(up_sum - 5'd12) : 4'(up_sum);
                if (!found && scale[dn_cls]) begin
                    found = 1'b1;
                    if (dn_sum >= 5'd12) begin
                        snap_note = dn_cls;
                    end else if (norm_oct_q == 3'd0) begin
                        snap_note = 4'd0;
                        snap_oct  = 3'd0;
                    end else begin
                        snap_note = dn_cls;
                        snap_oct  = norm_oct_q - 3'd1;
                    end
                end else if (!found && scale[up_cls]) begin
                    found = 1'b1;
                    if (up_sum < 5'd12) begin
                        snap_note = up_cls;
                    end else if (norm_oct_q == 3'd7) begin
                        snap_note = 4'd11;
                        snap_oct  = 3'd7;
                    end else begin
                        snap_note = up_cls;
                        snap_oct  = norm_oct_q + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        s1_valid_d    = accept;
        s1_addr_d     = accept ? fft_address : s1_addr_q;
        s1_mag_d      = accept ? mag : s1_mag_q;
        max_d         = max_q;
        peak_d        = peak_q;
        norm_note_d   = norm_note_q;
        norm_oct_d    = norm_oct_q;
        none_d        = none_q;
        note_name_d   = note_name_q;
        note_octave_d = note_octave_q;
        note_done_d   = 1'b0;
        done_d        = done_q;

        // Strict compare keeps the lowest bin on equal magnitudes
        if (s1_valid_q && !s1_addr_q[8] && s1_addr_q[7:0] != 8'd0 && s1_mag_q > max_q) begin
            max_d  = s1_mag_q;
            peak_d = s1_addr_q[7:0];
        end

        case (state_q)
            IDLE: begin
                if (fft_done) begin
                    state_d = CAPTURE;
                    last_d  = 1'b0;
                    max_d   = '0;
                    peak_d  = 8'd0;
                    done_d  = 1'b0;
                end
            end
            CAPTURE: begin
                if (accept && fft_address == 9'd511) last_d = 1'b1;
                if (last_q) state_d = NORM;
            end
            NORM: begin
                state_d = SNAP;
                none_d  = (peak_q == 8'd0);
                if (cnt == 4'd12) begin
                    norm_note_d = (msb == 3'd7) ? 4'd11 : 4'd0;
                    norm_oct_d  = (msb == 3'd7) ? 3'd7 : msb + 3'd1;
                end else begin
                    norm_note_d = cnt;
                    norm_oct_d  = msb;
                end
            end
            SNAP: begin
                state_d       = OUT;
                note_name_d   = none_q ? 4'd15 : snap_note;
                note_octave_d = none_q ? 3'd0 : snap_oct;
                note_done_d   = 1'b1;
                done_d        = 1'b1;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_mag_q      <= '0;
            max_q         <= '0;
            peak_q        <= 8'd0;
            norm_note_q   <= 4'd0;
            norm_oct_q    <= 3'd0;
            none_q        <= 1'b1;
            note_name_q   <= 4'd15;
            note_octave_q <= 3'd0;
            note_done_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            s1_valid_q    <= s1_valid_d;
            s1_addr_q     <= s1_addr_d;
            s1_mag_q      <= s1_mag_d;
            max_q         <= max_d;
            peak_q        <= peak_d;
            norm_note_q   <= norm_note_d;
            norm_oct_q    <= norm_oct_d;
            none_q        <= none_d;
            note_name_q   <= note_name_d;
            note_octave_q <= note_octave_d;
            note_done_q   <= note_done_d;
            done_q        <= done_d;
        end
    end

    // Magnitude RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (s1_valid_q) mem[s1_addr_q] <= s1_mag_q;
        result_data_q <= mem[result_address];
    end

    assign result_data = result_data_q;
    assign note_name   = note_name_q;
    assign note_octave = note_octave_q;
    assign note_done   = note_done_q;
    assign done        = done_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: streams whole frames and checks note results,
// pulse timing, scale snapping, RAM readback and reset behaviour.
module tb_main_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        fft_done;
    logic        fft_read_valid;
    logic [8:0]  fft_address;
    logic [17:0] data_in_real;
    logic [17:0] data_in_imag;
    logic [11:0] scale;
    logic [8:0]  result_address;
    logic [35:0] result_data;
    logic [3:0]  note_name;
    logic [2:0]  note_octave;
    logic        note_done;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [17:0] re_arr [512];
    logic signed [17:0] im_arr [512];

    main_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .fft_done       (fft_done),
        .fft_read_valid (fft_read_valid),
        .fft_address    (fft_address),
        .data_in_real   (data_in_real),
        .data_in_imag   (data_in_imag),
        .scale          (scale),
        .result_address (result_address),
        .result_data    (result_data),
        .note_name      (note_name),
        .note_octave    (note_octave),
        .note_done      (note_done),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 512; i++) begin
            re_arr[i] = 18'sd0;
            im_arr[i] = 18'sd0;
        end
    endtask

    // Start a capture, stream bins 0..511, then watch six cycles for the pulse
    task automatic run_frame(input string tag, input int exp_note, input int exp_oct);
        int first;
        int pulses;
        @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        check_eq({tag, "_done_clr"}, 64'(done), 64'd0);
        for (int a = 0; a < 512; a++) begin
            fft_read_valid = 1'b1;
            fft_address    = 9'(a);
            data_in_real   = re_arr[a];
            data_in_imag   = im_arr[a];
            @(negedge clk);
        end
        fft_read_valid = 1'b0;
        first  = 0;
        pulses = 0;
        for (int n = 1; n <= 6; n++) begin
            if (note_done) begin
                pulses++;
                if (first == 0) first = n;
            end
            if (n < 6) @(negedge clk);
        end
        check_eq({tag, "_pulse_cycle"}, 64'(first), 64'd4);
        check_eq({tag, "_pulse_count"}, 64'(pulses), 64'd1);
        check_eq({tag, "_note"}, 64'(note_name), 64'(exp_note));
        check_eq({tag, "_oct"}, 64'(note_octave), 64'(exp_oct));
        check_eq({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic read_ram(input string tag, input int addr, input logic [35:0] exp);
        @(negedge clk);
        result_address = 9'(addr);
        @(negedge clk);
        check_eq(tag, 64'(result_data), 64'(exp));
    endtask

    initial begin
        int pulses;
        reset          = 1'b1;
        fft_done       = 1'b0;
        fft_read_valid = 1'b0;
        fft_address    = 9'd0;
        data_in_real   = 18'd0;
        data_in_imag   = 18'd0;
        scale          = 12'hFFF;
        result_address = 9'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_note", 64'(note_name), 64'd15);
        check_eq("rst_oct", 64'(note_octave), 64'd0);
        check_eq("rst_note_done", 64'(note_done), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);

        clear_frame();
        re_arr[64] = 18'sd1000;
        run_frame("bin64", 0, 6);
        read_ram("ram64", 64, 36'd1000000);
        check_eq("done_hold", 64'(done), 64'd1);

        clear_frame();
        re_arr[100] = 18'sd1000;
        run_frame("bin100", 8, 6);
        scale = 12'b111011010111;
        run_frame("bin100_snap_tie", 7, 6);

        scale = 12'h800;
        clear_frame();
        re_arr[64] = 18'sd1000;
        run_frame("snap_wrap_down", 11, 5);

        scale = 12'h001;
        clear_frame();
        re_arr[120] = 18'sd1000;
        run_frame("snap_wrap_up", 0, 7);

        scale = 12'hFFF;
        clear_frame();
        re_arr[70] = 18'sd500;
        re_arr[90] = -18'sd500;
        run_frame("peak_tie", 2, 6);

        clear_frame();
        re_arr[255] = 18'sd1000;
        re_arr[300] = 18'sd5000;
        run_frame("bin255", 11, 7);
        read_ram("ram300", 300, 36'd25000000);

        clear_frame();
        re_arr[5] = 18'sd3;
        im_arr[5] = -18'sd4;
        run_frame("bin5", 4, 2);
        read_ram("ram5", 5, 36'd25);

        clear_frame();
        run_frame("zero", 15, 0);
        read_ram("ram5_zero", 5, 36'd0);

        // Abort a frame with reset at bin 200
        clear_frame();
        re_arr[64] = 18'sd1000;
        @(negedge clk);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
        for (int a = 0; a <= 200; a++) begin
            fft_read_valid = 1'b1;
            fft_address    = 9'(a);
            data_in_real   = re_arr[a];
            data_in_imag   = im_arr[a];
            if (a == 200) reset = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        reset          = 1'b0;
        fft_read_valid = 1'b0;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            if (note_done) pulses++;
            @(negedge clk);
        end
        check_eq("abort_no_pulse", 64'(pulses), 64'd0);
        check_eq("abort_note", 64'(note_name), 64'd15);
        check_eq("abort_oct", 64'(note_octave), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        run_frame("after_abort", 0, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
